riscv_pipe_stage_buf: RTL

//  - Parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
//  - Carries NCH parallel data channels of DW bits each, e.g. PC / instr / imm between RISC-V stages.
//  - Adds back-pressure, pipeline flush and occupancy reporting, without a combinational ready path.

---
 rtl/riscv_pipe_stage_buf_pkg.sv | 14 +
 rtl/riscv_pipe_slot.sv | 21 ++
 rtl/riscv_pipe_stage_buf.sv | 132 +++++++++++++
 3 files changed

// File: rtl/riscv_pipe_stage_buf_pkg.sv
// Shared types for the pipeline stage buffer.
// State encoding doubles as the reported occupancy level.
package riscv_pipe_stage_buf_pkg;

    localparam int XLEN    = 32;
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        PSB_EMPTY = 2'd0,
        PSB_BUSY  = 2'd1,
        PSB_FULL  = 2'd2
    } psb_state_e;

endpackage

// File: rtl/riscv_pipe_slot.sv
// Wide data register with load enable and synchronous reset value.
module riscv_pipe_slot #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q <= RST_VAL;
        end else if (i_load) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/riscv_pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and 2-entry skid buffer.
// Define RISCV_PIPE_STAGE_STATS_EN to add the o_stall_cnt back-pressure counter.
module riscv_pipe_stage_buf
    import riscv_pipe_stage_buf_pkg::*;
#(
    parameter int            DW        = XLEN,
    parameter int            NCH       = 3,
    parameter logic [DW-1:0] RESET_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [NCH*DW-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NCH*DW-1:0] o_data,
    input  logic              i_flush,
    output logic [1:0]        o_level
`ifdef RISCV_PIPE_STAGE_STATS_EN
    ,
    output logic [STALL_W-1:0] o_stall_cnt
`endif
);

    localparam int                W       = NCH * DW;
    localparam logic [W-1:0]      RST_ALL = {NCH{RESET_VAL}};

    psb_state_e   state_q;
    psb_state_e   state_d;
    logic         load_m;
    logic         load_s;
    logic         m_from_s;
    logic         in_fire;
    logic         out_fire;
    logic [W-1:0] m_q;
    logic [W-1:0] s_q;
    logic [W-1:0] m_d;

    // Ready and valid come straight from the state register.
    assign o_ready  = (state_q != PSB_FULL);
    assign o_valid  = (state_q != PSB_EMPTY);
    assign o_level  = state_q;
    assign o_data   = m_q;
    assign in_fire  = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;
    assign m_d      = m_from_s ? s_q : i_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= PSB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        unique case (state_q)
            PSB_EMPTY: begin
                if (in_fire) begin
                    load_m  = 1'b1;
                    state_d = PSB_BUSY;
                end
            end
            PSB_BUSY: begin
                if (in_fire && out_fire) begin
                    load_m = 1'b1;
                end else if (in_fire) begin
                    load_s  = 1'b1;
                    state_d = PSB_FULL;
                end else if (out_fire) begin
                    state_d = PSB_EMPTY;
                end
            end
            PSB_FULL: begin
                if (out_fire) begin
                    load_m   = 1'b1;
                    m_from_s = 1'b1;
                    state_d  = PSB_BUSY;
                end
            end
            default: state_d = PSB_EMPTY;
        endcase
        // Flush drops everything; slot contents are left as they were.
        if (i_flush) begin
            state_d = PSB_EMPTY;
            load_m  = 1'b0;
            load_s  = 1'b0;
        end
    end

    riscv_pipe_slot #(
        .W       (W),
        .RST_VAL (RST_ALL)
    ) u_main (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (load_m),
        .i_d    (m_d),
        .o_q    (m_q)
    );

    riscv_pipe_slot #(
        .W       (W),
        .RST_VAL (RST_ALL)
    ) u_skid (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (load_s),
        .i_d    (i_data),
        .o_q    (s_q)
    );

`ifdef RISCV_PIPE_STAGE_STATS_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q <= '0;
        end else if (o_valid && !i_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule
